// File: rtl/pc_redirect_fetch.sv
// rtl/pc_redirect_fetch.sv - fetch PC and IF/ID register with branch redirect, flush shadow and perf counters
module pc_redirect_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                SHADOW   = 2,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic [2:0]        addr_sel_in,
  input  logic              less_in,
  input  logic              zero_in,
  input  logic [ADDR_W-1:0] br_target_in,
  input  logic [ADDR_W-1:0] jalr_target_in,
  input  logic [31:0]       imem_instr_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ifid_pc_out,
  output logic [31:0]       ifid_instr_out,
  output logic              ifid_valid_out,
  output logic              redirect_out,
  output logic              misalign_out,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  squash_cnt
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Shadow counter only needs to hold SHADOW-1.
  localparam int SC_W = (SHADOW > 1) ? $clog2(SHADOW) : 1;
  localparam logic [SC_W-1:0] SHADOW_INIT = SC_W'((SHADOW > 0) ? (SHADOW - 1) : 0);
  localparam logic [ADDR_W-1:0] JALR_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  state_t            r_state;
  logic [SC_W-1:0]   r_shadow_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ifid_pc;
  logic [31:0]       r_ifid_instr;
  logic              r_ifid_valid;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_redirect_cnt;
  logic [CNT_W-1:0]  r_squash_cnt;

  logic              w_taken;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target_raw;
  logic [ADDR_W-1:0] w_target_pc;

  // Decode the resolved branch/jump into a taken flag and its raw target.
  always_comb begin
    w_taken = 1'b0;
    case (addr_sel_in)
      3'd1:    w_taken = less_in;
      3'd2:    w_taken = zero_in;
      3'd3:    w_taken = 1'b1;
      3'd4:    w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
    w_target_raw = (addr_sel_in == 3'd4) ? (jalr_target_in & JALR_MASK) : br_target_in;
    w_target_pc  = {w_target_raw[ADDR_W-1:2], 2'b00};
  end

  // Resolution inputs are only trusted outside the flush shadow.
  assign w_redirect = w_taken & (r_state == ST_RUN);

  // Flush-shadow FSM: counts down every cycle (stalled or not) after a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect && (SHADOW != 0)) begin
            r_state      <= ST_SHADOW;
            r_shadow_cnt <= SHADOW_INIT;
          end
        end
        ST_SHADOW: begin
          if (r_shadow_cnt == '0) begin
            r_state <= ST_RUN;
          end else begin
            r_shadow_cnt <= r_shadow_cnt - 1'b1;
          end
        end
        default: begin
          r_state      <= ST_RUN;
          r_shadow_cnt <= '0;
        end
      endcase
    end
  end

  // PC and IF/ID update: redirect beats stall, stall beats sequential fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      r_misalign   <= 1'b0;
    end else if (w_redirect) begin
      r_pc         <= w_target_pc;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
      if (w_target_raw[1]) begin
        r_misalign <= 1'b1;
      end
    end else if (!stall_in) begin
      r_pc         <= r_pc + ADDR_W'(4);
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= imem_instr_in;
      r_ifid_valid <= 1'b1;
    end
  end

  // Saturating performance counters; every accepted redirect loads exactly one bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
      r_squash_cnt   <= '0;
    end else if (w_redirect) begin
      if (r_redirect_cnt != '1) begin
        r_redirect_cnt <= r_redirect_cnt + 1'b1;
      end
      if (r_squash_cnt != '1) begin
        r_squash_cnt <= r_squash_cnt + 1'b1;
      end
    end
  end

  assign pc_out         = r_pc;
  assign ifid_pc_out    = r_ifid_pc;
  assign ifid_instr_out = r_ifid_instr;
  assign ifid_valid_out = r_ifid_valid;
  assign redirect_out   = w_redirect;
  assign misalign_out   = r_misalign;
  assign redirect_cnt   = r_redirect_cnt;
  assign squash_cnt     = r_squash_cnt;

endmodule

// File: tb/tb_pc_redirect_fetch.sv
// tb/tb_pc_redirect_fetch.sv - randomized self-checking bench for pc_redirect_fetch
module tb_pc_redirect_fetch;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          SHADOW   = 2;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall_in;
  logic [2:0]        addr_sel_in;
  logic              less_in;
  logic              zero_in;
  logic [ADDR_W-1:0] br_target_in;
  logic [ADDR_W-1:0] jalr_target_in;
  logic [31:0]       imem_instr_in;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] ifid_pc_out;
  logic [31:0]       ifid_instr_out;
  logic              ifid_valid_out;
  logic              redirect_out;
  logic              misalign_out;
  logic [CNT_W-1:0]  redirect_cnt;
  logic [CNT_W-1:0]  squash_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0]      m_pc;
  logic [31:0]      m_ifid_pc;
  logic [31:0]      m_ifid_instr;
  logic             m_ifid_valid;
  logic             m_mis;
  int               m_rcnt;
  int               m_scnt;
  int               m_masked_left;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {a[29:0], 2'b01} ^ 32'h1234_5678;
  endfunction

  assign imem_instr_in = imem_f(pc_out);

  pc_redirect_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .SHADOW  (SHADOW),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .addr_sel_in   (addr_sel_in),
    .less_in       (less_in),
    .zero_in       (zero_in),
    .br_target_in  (br_target_in),
    .jalr_target_in(jalr_target_in),
    .imem_instr_in (imem_instr_in),
    .pc_out        (pc_out),
    .ifid_pc_out   (ifid_pc_out),
    .ifid_instr_out(ifid_instr_out),
    .ifid_valid_out(ifid_valid_out),
    .redirect_out  (redirect_out),
    .misalign_out  (misalign_out),
    .redirect_cnt  (redirect_cnt),
    .squash_cnt    (squash_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit model_taken(input logic [2:0] sel, input logic lt, input logic z);
    return (sel == 3'd1 && lt) || (sel == 3'd2 && z) || sel == 3'd3 || sel == 3'd4;
  endfunction

  // One clock: drive inputs, check the combinational redirect, clock, advance model, check state.
  task automatic step(input bit r, input bit st, input logic [2:0] sel, input bit lt, input bit z,
                      input logic [31:0] br, input logic [31:0] jr);
    bit          acc;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; stall_in = st; addr_sel_in = sel; less_in = lt; zero_in = z;
    br_target_in = br; jalr_target_in = jr;
    #1;
    acc = model_taken(sel, lt, z) && (m_masked_left == 0);
    check("redirect_out", {63'd0, redirect_out}, {63'd0, acc});
    @(posedge clk);
    if (r) begin
      m_pc = RESET_PC; m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
      m_mis = 0; m_rcnt = 0; m_scnt = 0; m_masked_left = 0;
    end else if (acc) begin
      tgt = (sel == 3'd4) ? (jr & 32'hFFFF_FFFE) : br;
      if (tgt[1]) m_mis = 1;
      m_pc = tgt & 32'hFFFF_FFFC;
      m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
      if (m_rcnt < int'(CMAX)) m_rcnt++;
      if (m_scnt < int'(CMAX)) m_scnt++;
      m_masked_left = SHADOW;
    end else begin
      if (m_masked_left > 0) m_masked_left--;
      if (!st) begin
        m_ifid_pc = m_pc; m_ifid_instr = imem_f(m_pc); m_ifid_valid = 1;
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check("pc_out", 64'(pc_out), 64'(m_pc));
    check("ifid_pc", 64'(ifid_pc_out), 64'(m_ifid_pc));
    check("ifid_instr", 64'(ifid_instr_out), 64'(m_ifid_instr));
    check("ifid_valid", 64'(ifid_valid_out), 64'(m_ifid_valid));
    check("misalign", 64'(misalign_out), 64'(m_mis));
    check("redirect_cnt", 64'(redirect_cnt), 64'(m_rcnt));
    check("squash_cnt", 64'(squash_cnt), 64'(m_scnt));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 3'd0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1; stall_in = 0; addr_sel_in = 0; less_in = 0; zero_in = 0;
    br_target_in = 0; jalr_target_in = 0;
    m_pc = 0; m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_valid = 0;
    m_mis = 0; m_rcnt = 0; m_scnt = 0; m_masked_left = 0;

    // reset and sequential fetch
    step(1, 0, 3'd0, 0, 0, 0, 0);
    check("rst_pc_const", 64'(pc_out), 64'(RESET_PC));
    check("rst_valid_const", 64'(ifid_valid_out), 64'd0);
    check("rst_instr_const", 64'(ifid_instr_out), 64'(NOP));
    idle(4);
    check("seq_pc_16", 64'(pc_out), 64'h10);

    // beq taken at pc 0x10
    step(0, 0, 3'd2, 0, 1, 32'h40, 32'h0);
    check("beq_pc_40", 64'(pc_out), 64'h40);
    check("beq_squash_1", 64'(squash_cnt), 64'd1);
    idle(2);

    // blt not taken, then misaligned jalr
    step(0, 0, 3'd1, 0, 0, 32'h100, 32'h0);
    step(0, 0, 3'd4, 0, 0, 32'h100, 32'h83);
    check("jalr_pc_80", 64'(pc_out), 64'h80);
    check("jalr_misalign", 64'(misalign_out), 64'd1);
    idle(3);
    check("misalign_sticky", 64'(misalign_out), 64'd1);

    // redirect coinciding with stall
    step(0, 1, 3'd3, 0, 0, 32'h200, 32'h0);
    check("stall_redir_pc", 64'(pc_out), 64'h200);
    idle(2);

    // shadow masking: two ignored jal, third accepted
    step(0, 0, 3'd3, 0, 0, 32'h300, 32'h0);
    step(0, 0, 3'd3, 0, 0, 32'h400, 32'h0);
    step(0, 1, 3'd3, 0, 0, 32'h500, 32'h0);
    step(0, 0, 3'd3, 0, 0, 32'h600, 32'h0);
    check("shadow_third_pc", 64'(pc_out), 64'h600);
    idle(2);

    // PC wrap
    step(0, 0, 3'd3, 0, 0, 32'hFFFF_FFFC, 32'h0);
    idle(1);
    check("wrap_pc_0", 64'(pc_out), 64'h0);

    // reset in the middle of the shadow
    step(0, 0, 3'd3, 0, 0, 32'h700, 32'h0);
    step(1, 0, 3'd0, 0, 0, 0, 0);
    step(0, 0, 3'd3, 0, 0, 32'h800, 32'h0);
    check("post_rst_accept", 64'(pc_out), 64'h800);

    // counter saturation
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 3'd4, 0, 0, 32'h0, 32'h1000 + 32'(k * 16));
      idle(2);
    end
    check("sat_redirect", 64'(redirect_cnt), 64'(CMAX));

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
           $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
